// File: rtl/m_imem_loader_pkg.sv
// Definitions shared by the instruction-memory loader and the memory-loading top:
// loader state encodings, the default frame sync byte and the instruction-memory geometry.
package m_imem_loader_pkg;

  localparam int         IMEM_ADDR_W    = 12;
  localparam int         IMEM_MAX_WORDS = 4096;
  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

endpackage

// File: rtl/m_imem_loader_packer.sv
// Byte-to-word packer: little-endian lane shift register, lane counter and running
// XOR of every payload byte. Flags the cycle in which the fourth byte of a word arrives.
module m_byte_packer (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        i_clear,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic        o_word_fire,
  output logic [31:0] o_word,
  output logic [7:0]  o_csum
);

  logic [1:0]  r_lane;
  logic [31:0] r_shift;
  logic [7:0]  r_csum;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_lane  <= '0;
      r_shift <= '0;
      r_csum  <= '0;
    end else if (i_clear) begin
      r_lane  <= '0;
      r_shift <= '0;
      r_csum  <= '0;
    end else if (i_shift) begin
      r_lane  <= r_lane + 2'd1;
      r_shift <= {i_byte, r_shift[31:8]};
      r_csum  <= r_csum ^ i_byte;
    end
  end

  // Bytes enter at the top and shift down, so the first byte of a word lands in [7:0].
  assign o_word_fire = i_shift && (r_lane == 2'd3);
  assign o_word      = {i_byte, r_shift[31:8]};
  assign o_csum      = r_csum;

endmodule

// File: rtl/m_imem_loader.sv
// Instruction-memory loader: parses a framed byte stream, writes packed words to
// sequential addresses and releases the processor clock enable after a good checksum.
module m_imem_loader
  import m_imem_loader_pkg::*;
#(
  parameter int         ADDR_W    = IMEM_ADDR_W,
  parameter int         MAX_WORDS = IMEM_MAX_WORDS,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic [7:0]        w_rx_data,
  input  logic              w_rx_valid,
  output logic              r_rx_ready,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_waddr,
  output logic [31:0]       r_wdata,
  output logic              r_ce,
  output logic              r_err,
  output logic              r_busy
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_len_lo;
  logic [15:0] r_len;
  logic [15:0] r_widx;

  logic        w_accept;
  logic        w_shift;
  logic        w_clear;
  logic        w_word_fire;
  logic [31:0] w_word;
  logic [7:0]  w_csum;
  logic [15:0] w_len_full;
  logic        w_last_word;

  assign w_accept    = w_rx_valid && r_rx_ready;
  assign w_shift     = w_accept && (r_state == S_DATA);
  assign w_clear     = (r_state == S_SYNC);
  assign w_len_full  = {w_rx_data, r_len_lo};
  assign w_last_word = (r_widx == (r_len - 16'd1));

  m_byte_packer u_packer (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .i_clear     (w_clear),
    .i_shift     (w_shift),
    .i_byte      (w_rx_data),
    .o_word_fire (w_word_fire),
    .o_word      (w_word),
    .o_csum      (w_csum)
  );

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) r_state <= S_SYNC;
    else       r_state <= w_next;
  end

  // NOTE: next state is defaulted first so no path through the case infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_SYNC: if (w_accept && (w_rx_data == SYNC_BYTE)) w_next = S_LEN0;
      S_LEN0: if (w_accept) w_next = S_LEN1;
      S_LEN1: begin
        if (w_accept) begin
          if (w_len_full == 16'd0)                w_next = S_CSUM;
          else if ({1'b0, w_len_full} > MAX_LEN)  w_next = S_ERR;
          else                                    w_next = S_DATA;
        end
      end
      S_DATA: if (w_word_fire && w_last_word) w_next = S_CSUM;
      S_CSUM: if (w_accept) w_next = (w_rx_data == w_csum) ? S_DONE : S_ERR;
      S_DONE: w_next = S_DONE;
      S_ERR:  w_next = S_ERR;
      default: w_next = S_SYNC;
    endcase
  end

  // Status outputs follow the next state so they change on the same edge as the state.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_len_lo   <= '0;
      r_len      <= '0;
      r_widx     <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_ce       <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_ready <= 1'b1;
    end else begin
      r_we <= w_word_fire;
      if (w_word_fire) begin
        r_waddr <= r_widx[ADDR_W-1:0];
        r_wdata <= w_word;
        r_widx  <= r_widx + 16'd1;
      end
      if (w_accept && (r_state == S_LEN0)) r_len_lo <= w_rx_data;
      if (w_accept && (r_state == S_LEN1)) begin
        r_len  <= w_len_full;
        r_widx <= '0;
      end
      r_rx_ready <= !((w_next == S_DONE) || (w_next == S_ERR));
      r_ce       <= (w_next == S_DONE);
      r_err      <= (w_next == S_ERR);
      r_busy     <= (w_next == S_LEN0) || (w_next == S_LEN1) ||
                    (w_next == S_DATA) || (w_next == S_CSUM);
    end
  end

endmodule
